pixel_write_arbiter: RTL and testbench
======================================

Name: pixel_write_arbiter

Overview:
- Shares the single framebuffer write port among three pixel producers: fill drawer (index 0), symbol drawer (index 1) and plot logic (index 2).
- Round-robin grant at burst granularity.
- Computes the linear framebuffer address from (x, y) and the back-buffer select.
- Owns the double-buffer select: a front/back swap is performed only when no burst is granted and no write is in flight.
- Sits between the drawing engines sequenced by the graphics FSM and the framebuffer RAM / VGA scanout.

Parameters:
- HOR_ACTIVE_PIXELS, 640, framebuffer width in pixels
- VER_ACTIVE_PIXELS, 480, framebuffer height in pixels
- COLOR_WIDTH, 1, bits per pixel
- N_REQ, 3, number of requesters (fixed 3 in this revision)
- Derived localparams:
  - X_WIDTH = $clog2(HOR_ACTIVE_PIXELS)
  - Y_WIDTH = $clog2(VER_ACTIVE_PIXELS)
  - ADDR_WIDTH = $clog2(2*HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS)

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  per-requester pixel valid
- req_last  in  N_REQ  marks final pixel of requester's burst
- req_x  in  N_REQ*X_WIDTH  packed x, requester i at [i*X_WIDTH +: X_WIDTH]
- req_y  in  N_REQ*Y_WIDTH  packed y
- req_color  in  N_REQ*COLOR_WIDTH  packed color
- req_ready  out  N_REQ  per-requester accept
- fb_we  out  1  framebuffer write valid
- fb_addr  out  ADDR_WIDTH  linear write address
- fb_data  out  COLOR_WIDTH  write data
- fb_ready  in  1  framebuffer accepts write this cycle
- swap_req  in  1  level request to swap buffers; held until swap_ack
- swap_ack  out  1  one-cycle pulse when swap is performed
- front_buffer  out  1  buffer index being scanned out; back buffer = ~front_buffer
- busy  out  1  high when state is GRANT or fb_we is high

Behaviour:
- Reset (rst=1 at posedge, also mid-operation):
  - state=IDLE, owner=0, rr_ptr=0, fb_we=0, fb_addr=0, fb_data=0, swap_ack=0, front_buffer=0, busy=0.
  - Any in-flight burst is abandoned; requesters must restart.
- out_free = ~fb_we | fb_ready.
- Output register: beat accepted when req_valid[owner] & req_ready[owner]. Next cycle:
  - fb_we=1
  - fb_addr = (~front_buffer)*H*V + y*H + x, computed at ADDR_WIDTH without truncation
  - fb_data=color
- fb_we/fb_addr/fb_data hold stable while fb_we & ~fb_ready. fb_we clears after fb_ready unless a new beat is accepted.
- Latency: one cycle from acceptance to fb_we. Throughput: one pixel per cycle while fb_ready=1.
- State IDLE:
  - All req_ready=0; swap_ack=0 except on the swap cycle.
  - Swap has priority over grant: if swap_req & ~fb_we, toggle front_buffer and pulse swap_ack; stay IDLE that cycle.
  - Else if any req_valid: owner = first valid index at or after rr_ptr (cyclic); go to GRANT.
- State GRANT:
  - req_ready[owner]=out_free; other ready bits 0.
  - On an accepted beat with req_last=1: rr_ptr=(owner+1) mod N_REQ; go to IDLE. This costs one bubble cycle before the next grant.
- Requests from non-owners and swap_req pend without effect during GRANT.
- swap_req rising during a burst: swap occurs in the first IDLE cycle with fb_we=0, i.e. after the last pixel is written.
- swap_req and req_valid in the same IDLE cycle: swap wins, grant follows next cycle.
- A requester dropping req_valid mid-burst keeps the grant; there is no timeout.
- Single-pixel burst: valid and last asserted together.

Optional Feature:
- Macro: PIXEL_CLIP_EN.
- Defined:
  - A beat with x>=HOR_ACTIVE_PIXELS or y>=VER_ACTIVE_PIXELS is accepted (ready, burst/last handling unchanged) but not forwarded: fb_we is not set for it.
  - A 16-bit saturating output clip_count (reset 0) increments per clipped beat.
- Not defined: no check; the address is computed as written and may alias into the other buffer. The clip_count port is absent.

Decomposition:
- Shared include graphics_defs.vh:
  - HOR_ACTIVE_PIXELS/VER_ACTIVE_PIXELS defaults
  - requester index localparams REQ_FILL=0, REQ_SYMBOL=1, REQ_PLOT=2
  - state encodings STATE_IDLE=0, STATE_GRANT=1
- Sub-module rr_arbiter: combinational cyclic priority select of valid vector from rr_ptr, returning a one-hot grant and its index.

Test Plan:
- Single requester 1, burst of 4 pixels x=0..3, y=0, fb_ready=1, front_buffer=0 -> fb_addr 307200..307203 on consecutive cycles, first fb_we 2 cycles after req_valid rises (grant + accept), other req_ready stay 0.
- Requesters 0 and 2 both valid at rr_ptr=0, 2-pixel bursts each -> requester 0 served fully, one bubble, then requester 2; rr_ptr=0 after completion (2+1 mod 3).
- fb_ready low 3 cycles mid-burst (x=3,y=2, back=1) -> fb_we, fb_addr=308483 and fb_data held; req_ready[owner]=0 during the stall; no beat lost or duplicated.
- swap_req asserted during requester 1 burst -> no swap_ack until the last write completes with fb_ready; then exactly one swap_ack pulse, front_buffer 0->1; subsequent x=0,y=0 write goes to fb_addr 0.
- rst pulsed mid-burst with fb_we=1 -> next cycle fb_we=0, all req_ready=0, front_buffer=0, state IDLE; a fresh burst is granted normally.
- PIXEL_CLIP_EN: beat x=640,y=0 inside 3-pixel burst -> accepted, no fb_we for it, clip_count=1; other two pixels written.

Source files
------------

// File: rtl/pixel_write_arbiter_pkg.sv
// Shared definitions for the pixel write arbiter: framebuffer geometry
// defaults, requester indices and FSM state encoding.
// Imported by pixel_write_arbiter and its testbench.
package pixel_write_arbiter_pkg;

    localparam int DEF_HOR_ACTIVE_PIXELS = 640;
    localparam int DEF_VER_ACTIVE_PIXELS = 480;

    // Requester slots on the packed request buses
    localparam int REQ_FILL   = 0;
    localparam int REQ_SYMBOL = 1;
    localparam int REQ_PLOT   = 2;

    typedef enum logic {
        STATE_IDLE  = 1'b0,
        STATE_GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/pixel_write_arbiter_rr_arbiter.sv
// Purpose: cyclic priority select over a valid vector, starting at ptr.
// Latency: combinational.
// Backpressure: none; pure select logic.
// Ports: valid (request vector), ptr (highest-priority index),
//        grant (one-hot winner, zero if nothing valid), grant_idx (winner index).
module rr_arbiter #(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] cand;

    // Walk from the farthest offset back to ptr so the nearest valid
    // index at or after ptr is the last one written and wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            cand = IDX_W'((int'(ptr) + off) % N_REQ);
            if (valid[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/pixel_write_arbiter.sv
// Purpose: shares the framebuffer write port among fill/symbol/plot drawers, round-robin per burst, owns front/back swap.
// Latency: one cycle from accepted beat to fb_we; one pixel per cycle while fb_ready is high.
// Backpressure: owner's req_ready follows out_free (~fb_we | fb_ready); fb_we/fb_addr/fb_data hold while stalled.
// Ports: clk/rst (sync, active-high); req_valid/req_last/req_x/req_y/req_color in, req_ready out per requester;
//        fb_we/fb_addr/fb_data out with fb_ready in; swap_req in, swap_ack/front_buffer out; busy out.
// Optional: PIXEL_CLIP_EN drops off-screen beats (still accepted) and adds the saturating clip_count output.
module pixel_write_arbiter
    import pixel_write_arbiter_pkg::*;
#(
    parameter int HOR_ACTIVE_PIXELS = DEF_HOR_ACTIVE_PIXELS,
    parameter int VER_ACTIVE_PIXELS = DEF_VER_ACTIVE_PIXELS,
    parameter int COLOR_WIDTH       = 1,
    parameter int N_REQ             = 3,
    localparam int X_WIDTH    = $clog2(HOR_ACTIVE_PIXELS),
    localparam int Y_WIDTH    = $clog2(VER_ACTIVE_PIXELS),
    localparam int ADDR_WIDTH = $clog2(2 * HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ-1:0]             req_last,
    input  logic [N_REQ*X_WIDTH-1:0]     req_x,
    input  logic [N_REQ*Y_WIDTH-1:0]     req_y,
    input  logic [N_REQ*COLOR_WIDTH-1:0] req_color,
    output logic [N_REQ-1:0]             req_ready,
    output logic                         fb_we,
    output logic [ADDR_WIDTH-1:0]        fb_addr,
    output logic [COLOR_WIDTH-1:0]       fb_data,
    input  logic                         fb_ready,
    input  logic                         swap_req,
    output logic                         swap_ack,
    output logic                         front_buffer,
`ifdef PIXEL_CLIP_EN
    output logic [15:0]                  clip_count,
`endif
    output logic                         busy
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [ADDR_WIDTH-1:0] BUF_PIXELS  = ADDR_WIDTH'(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS);
    localparam logic [ADDR_WIDTH-1:0] LINE_PIXELS = ADDR_WIDTH'(HOR_ACTIVE_PIXELS);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic                    fb_we_q, fb_we_d;
    logic [ADDR_WIDTH-1:0]   fb_addr_q, fb_addr_d;
    logic [COLOR_WIDTH-1:0]  fb_data_q, fb_data_d;
    logic                    swap_ack_q, swap_ack_d;
    logic                    front_q, front_d;

    logic [N_REQ-1:0]        arb_grant;
    logic [IDX_W-1:0]        arb_idx;

    logic                    sel_valid;
    logic                    sel_last;
    logic [X_WIDTH-1:0]      sel_x;
    logic [Y_WIDTH-1:0]      sel_y;
    logic [COLOR_WIDTH-1:0]  sel_color;

    logic                    out_free;
    logic                    beat_acc;
    logic                    beat_fwd;
    logic [ADDR_WIDTH-1:0]   pix_addr;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .valid     (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    // Current owner's request fields
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_x     = '0;
        sel_y     = '0;
        sel_color = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_x     = req_x[i*X_WIDTH +: X_WIDTH];
                sel_y     = req_y[i*Y_WIDTH +: Y_WIDTH];
                sel_color = req_color[i*COLOR_WIDTH +: COLOR_WIDTH];
            end
        end
    end

    assign out_free = ~fb_we_q | fb_ready;
    assign beat_acc = (state_q == STATE_GRANT) & sel_valid & out_free;

    // Writes always target the back buffer, i.e. the one not being scanned out.
    assign pix_addr = (front_q ? '0 : BUF_PIXELS)
                    + ADDR_WIDTH'(sel_y) * LINE_PIXELS
                    + ADDR_WIDTH'(sel_x);

`ifdef PIXEL_CLIP_EN
    localparam logic [X_WIDTH:0] X_LIMIT = (X_WIDTH + 1)'(HOR_ACTIVE_PIXELS);
    localparam logic [Y_WIDTH:0] Y_LIMIT = (Y_WIDTH + 1)'(VER_ACTIVE_PIXELS);

    logic        clip_beat;
    logic [15:0] clip_count_q, clip_count_d;

    // Extra top bit keeps the limit intact when the size is a power of two.
    assign clip_beat = ({1'b0, sel_x} >= X_LIMIT) | ({1'b0, sel_y} >= Y_LIMIT);
    assign beat_fwd  = beat_acc & ~clip_beat;

    always_comb begin
        clip_count_d = clip_count_q;
        if (beat_acc && clip_beat && (clip_count_q != 16'hFFFF)) begin
            clip_count_d = clip_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clip_count_q <= '0;
        end else begin
            clip_count_q <= clip_count_d;
        end
    end

    assign clip_count = clip_count_q;
`else
    assign beat_fwd = beat_acc;
`endif

    // Next-state logic for the grant FSM, output register and buffer select
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        fb_we_d    = fb_we_q;
        fb_addr_d  = fb_addr_q;
        fb_data_d  = fb_data_q;
        swap_ack_d = 1'b0;
        front_d    = front_q;

        // A clipped beat is consumed like any other but leaves the port idle;
        // out_free guaranteed any previous write has already been taken.
        if (beat_fwd) begin
            fb_we_d   = 1'b1;
            fb_addr_d = pix_addr;
            fb_data_d = sel_color;
        end else if (beat_acc || fb_ready) begin
            fb_we_d = 1'b0;
        end

        case (state_q)
            STATE_IDLE: begin
                // Swap only with the write port drained so no pixel of the
                // finished frame lands in the buffer now being displayed.
                if (swap_req && !fb_we_q) begin
                    front_d    = ~front_q;
                    swap_ack_d = 1'b1;
                end else if (|arb_grant) begin
                    owner_d = arb_idx;
                    state_d = STATE_GRANT;
                end
            end
            STATE_GRANT: begin
                if (beat_acc && sel_last) begin
                    rr_ptr_d = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                    state_d  = STATE_IDLE;
                end
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= STATE_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
            swap_ack_q <= 1'b0;
            front_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            fb_we_q    <= fb_we_d;
            fb_addr_q  <= fb_addr_d;
            fb_data_q  <= fb_data_d;
            swap_ack_q <= swap_ack_d;
            front_q    <= front_d;
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == STATE_GRANT) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (owner_q == IDX_W'(i)) begin
                    req_ready[i] = out_free;
                end
            end
        end
    end

    assign fb_we        = fb_we_q;
    assign fb_addr      = fb_addr_q;
    assign fb_data      = fb_data_q;
    assign swap_ack     = swap_ack_q;
    assign front_buffer = front_q;
    assign busy         = (state_q == STATE_GRANT) | fb_we_q;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Purpose: directed self-checking bench for pixel_write_arbiter.
// Latency: n/a.
// Backpressure: fb_ready is driven per test to create stalls.
module tb_pixel_write_arbiter;
    import pixel_write_arbiter_pkg::*;

    localparam int XW = 10;
    localparam int YW = 9;
    localparam int AW = 20;

    typedef struct packed {
        logic          last;
        logic          color;
        logic [YW-1:0] y;
        logic [XW-1:0] x;
    } pix_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    req_valid, req_last, req_ready, req_color;
    logic [3*XW-1:0] req_x;
    logic [3*YW-1:0] req_y;
    logic          fb_we, fb_ready, swap_req, swap_ack, front_buffer, busy;
    logic [AW-1:0] fb_addr;
    logic [0:0]    fb_data;
`ifdef PIXEL_CLIP_EN
    logic [15:0]   clip_count;
`endif

    always #5 clk = ~clk;

    pixel_write_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_x        (req_x),
        .req_y        (req_y),
        .req_color    (req_color),
        .req_ready    (req_ready),
        .fb_we        (fb_we),
        .fb_addr      (fb_addr),
        .fb_data      (fb_data),
        .fb_ready     (fb_ready),
        .swap_req     (swap_req),
        .swap_ack     (swap_ack),
        .front_buffer (front_buffer),
`ifdef PIXEL_CLIP_EN
        .clip_count   (clip_count),
`endif
        .busy         (busy)
    );

    pix_t q0[$], q1[$], q2[$];
    int   exp_addr[$], exp_data[$];
    int   acc_who[$], acc_cyc[$];
    int   n_vec = 0, n_bad = 0, cyc = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_slot(input int r, input bit v, input pix_t p);
        req_valid[r]          = v;
        req_last[r]           = p.last;
        req_color[r]          = p.color;
        req_x[r*XW +: XW]     = p.x;
        req_y[r*YW +: YW]     = p.y;
    endtask

    task automatic drive();
        if (q0.size() > 0) set_slot(0, 1'b1, q0[0]); else set_slot(0, 1'b0, '0);
        if (q1.size() > 0) set_slot(1, 1'b1, q1[0]); else set_slot(1, 1'b0, '0);
        if (q2.size() > 0) set_slot(2, 1'b1, q2[0]); else set_slot(2, 1'b0, '0);
    endtask

    task automatic push(input int r, input int x, input int y, input int c, input int l);
        pix_t p;
        p.x = XW'(x); p.y = YW'(y); p.color = c[0]; p.last = l[0];
        case (r)
            0: q0.push_back(p);
            1: q1.push_back(p);
            default: q2.push_back(p);
        endcase
    endtask

    task automatic expect_wr(input int a, input int d);
        exp_addr.push_back(a);
        exp_data.push_back(d);
    endtask

    // One clock: monitor writes and handshakes at negedge, advance producers after posedge.
    task automatic cycle();
        logic [2:0] acc;
        pix_t       tmp;
        @(negedge clk);
        cyc++;
        if (fb_we === 1'b1 && fb_ready === 1'b1) begin
            if (exp_addr.size() == 0) begin
                check_val("unexpected_write_addr", fb_addr, 32'hFFFF_FFFF);
            end else begin
                check_val("fb_addr", fb_addr, exp_addr.pop_front());
                check_val("fb_data", fb_data, exp_data.pop_front());
            end
        end
        acc = req_valid & req_ready;
        for (int r = 0; r < 3; r++) begin
            if (acc[r]) begin
                acc_who.push_back(r);
                acc_cyc.push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
        if (acc[0]) tmp = q0.pop_front();
        if (acc[1]) tmp = q1.pop_front();
        if (acc[2]) tmp = q2.pop_front();
        drive();
        #1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && q2.size() == 0 &&
                 exp_addr.size() == 0 && busy === 1'b0) && n < budget) begin
            cycle();
            n++;
        end
        check_val(tag, (n < budget), 1);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int pulses;
        bit early;
        bit found;

        rst = 1'b1; fb_ready = 1'b1; swap_req = 1'b0;
        req_valid = '0; req_last = '0; req_x = '0; req_y = '0; req_color = '0;

        // ---- reset state
        reset_dut();
        check_val("rst_fb_we", fb_we, 0);
        check_val("rst_fb_addr", fb_addr, 0);
        check_val("rst_fb_data", fb_data, 0);
        check_val("rst_swap_ack", swap_ack, 0);
        check_val("rst_front", front_buffer, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_ready", req_ready, 0);
`ifdef PIXEL_CLIP_EN
        check_val("rst_clip_count", clip_count, 0);
`endif

        // ---- single requester burst of 4 into back buffer 1
        for (int i = 0; i < 4; i++) begin
            push(REQ_SYMBOL, i, 0, (i == 1) ? 0 : 1, (i == 3) ? 1 : 0);
            expect_wr(307200 + i, (i == 1) ? 0 : 1);
        end
        drive();
        #1;
        check_val("t1_idle_ready", req_ready, 0);
        cycle();
        check_val("t1_grant_ready", req_ready, 3'b010);
        check_val("t1_grant_we", fb_we, 0);
        cycle();
        check_val("t1_first_we", fb_we, 1);
        check_val("t1_first_addr", fb_addr, 307200);
        wait_idle("t1_done", 40);

        // ---- two contenders from rr_ptr=0, 2-pixel bursts each
        reset_dut();
        acc_who.delete(); acc_cyc.delete();
        push(REQ_FILL, 10, 1, 1, 0);  push(REQ_FILL, 11, 1, 0, 1);
        push(REQ_PLOT, 20, 5, 1, 0);  push(REQ_PLOT, 21, 5, 1, 1);
        expect_wr(307850, 1); expect_wr(307851, 0);
        expect_wr(310420, 1); expect_wr(310421, 1);
        drive();
        wait_idle("t2_done", 40);
        check_val("t2_accepts", acc_who.size(), 4);
        if (acc_who.size() == 4) begin
            check_val("t2_order0", acc_who[0], REQ_FILL);
            check_val("t2_order1", acc_who[1], REQ_FILL);
            check_val("t2_order2", acc_who[2], REQ_PLOT);
            check_val("t2_order3", acc_who[3], REQ_PLOT);
            check_val("t2_gap1", acc_cyc[1] - acc_cyc[0], 1);
            check_val("t2_bubble", acc_cyc[2] - acc_cyc[0], 3);
            check_val("t2_gap3", acc_cyc[3] - acc_cyc[0], 4);
        end
        // rr_ptr should be back at 0: requester 0 beats requester 1
        acc_who.delete(); acc_cyc.delete();
        push(REQ_SYMBOL, 31, 0, 0, 1);
        push(REQ_FILL, 30, 0, 1, 1);
        expect_wr(307230, 1); expect_wr(307231, 0);
        drive();
        wait_idle("t2b_done", 40);
        check_val("t2b_accepts", acc_who.size(), 2);
        if (acc_who.size() == 2) begin
            check_val("t2b_first", acc_who[0], REQ_FILL);
            check_val("t2b_second", acc_who[1], REQ_SYMBOL);
        end

        // ---- fb_ready stall mid-burst on x=3,y=2 in back buffer 1
        push(REQ_FILL, 2, 2, 0, 0); push(REQ_FILL, 3, 2, 1, 0); push(REQ_FILL, 4, 2, 0, 1);
        expect_wr(308482, 0); expect_wr(308483, 1); expect_wr(308484, 0);
        drive();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (fb_we === 1'b1 && fb_addr === 20'd308483) found = 1'b1;
        end
        check_val("t3_reach_stall", found, 1);
        fb_ready = 1'b0;
        #1;
        check_val("t3_stall_ready0", req_ready, 0);
        for (int i = 1; i <= 3; i++) begin
            cycle();
            check_val("t3_hold_we", fb_we, 1);
            check_val("t3_hold_addr", fb_addr, 308483);
            check_val("t3_hold_data", fb_data, 1);
            check_val("t3_hold_ready", req_ready, 0);
        end
        fb_ready = 1'b1;
        wait_idle("t3_done", 40);

        // ---- swap requested during a burst waits for the last write
        push(REQ_SYMBOL, 5, 0, 1, 0); push(REQ_SYMBOL, 6, 0, 0, 0); push(REQ_SYMBOL, 7, 0, 1, 1);
        expect_wr(307205, 1); expect_wr(307206, 0); expect_wr(307207, 1);
        drive();
        cycle();
        swap_req = 1'b1;
        pulses = 0;
        early = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (swap_ack === 1'b1) begin
                pulses++;
                if (exp_addr.size() != 0 || q1.size() != 0) early = 1'b1;
                swap_req = 1'b0;
            end
        end
        check_val("t4_pulses", pulses, 1);
        check_val("t4_early", early, 0);
        check_val("t4_front", front_buffer, 1);
        push(REQ_PLOT, 0, 0, 1, 1);
        expect_wr(0, 1);
        drive();
        wait_idle("t4_write0", 40);

        // ---- reset mid-burst with a write pending
        for (int i = 0; i < 4; i++) begin
            push(REQ_FILL, i, 10, 1, (i == 3) ? 1 : 0);
            expect_wr(6400 + i, 1);
        end
        drive();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (fb_we === 1'b1) found = 1'b1;
        end
        check_val("t5_reach_we", found, 1);
        rst = 1'b1;
        cycle();
        check_val("t5_fb_we", fb_we, 0);
        check_val("t5_ready", req_ready, 0);
        check_val("t5_front", front_buffer, 0);
        check_val("t5_busy", busy, 0);
        q0.delete(); q1.delete(); q2.delete();
        exp_addr.delete(); exp_data.delete();
        drive();
        rst = 1'b0;
        push(REQ_SYMBOL, 1, 0, 1, 0); push(REQ_SYMBOL, 2, 0, 0, 1);
        expect_wr(307201, 1); expect_wr(307202, 0);
        drive();
        wait_idle("t5_fresh", 40);

`ifdef PIXEL_CLIP_EN
        // ---- off-screen beat is consumed but never written
        push(REQ_FILL, 100, 0, 1, 0); push(REQ_FILL, 640, 0, 1, 0); push(REQ_FILL, 101, 0, 0, 1);
        expect_wr(307300, 1); expect_wr(307301, 0);
        drive();
        wait_idle("t6_done", 40);
        check_val("t6_clip_count", clip_count, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
